// File: rtl/conv_window_former.sv
// 3x3 sliding-window former fed by the live pixel plus two line-delayed taps.
// Define CONV_WINDOW_STRIDE2_EN to emit only even-aligned (stride-2) windows.
module conv_window_former #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    input  logic                          sof,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [DATA_WIDTH-1:0]         tap_r1,
    input  logic [DATA_WIDTH-1:0]         tap_r2,
    output logic                          win_valid,
    output logic [9*DATA_WIDTH-1:0]       win,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
    output logic                          frame_done,
    output logic                          err,
    output logic                          busy
);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [RW-1:0] row, pos_row;
    logic [CW-1:0] col, pos_col;
    logic accept, restart, violation, last_pix, win_ok;
    logic [9*DATA_WIDTH-1:0] wreg, wshift;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid && sof) state_nxt = RUN;
            RUN:  if (!in_valid || last_pix) state_nxt = IDLE;
        endcase
    end

    // Inside a frame every cycle must carry a pixel; sof there restarts the frame.
    always_comb begin
        accept    = 1'b0;
        restart   = 1'b0;
        violation = 1'b0;
        unique case (state)
            IDLE: begin
                accept  = in_valid && sof;
                restart = in_valid && sof;
            end
            RUN: begin
                accept    = in_valid;
                restart   = in_valid && sof;
                violation = !in_valid || sof;
            end
        endcase
    end

    assign busy     = (state == RUN);
    assign pos_row  = restart ? '0 : row;
    assign pos_col  = restart ? '0 : col;
    assign last_pix = accept && (pos_row == ROW_LAST) && (pos_col == COL_LAST);

`ifdef CONV_WINDOW_STRIDE2_EN
    assign win_ok = accept && (pos_row >= ROW_TWO) && (pos_col >= COL_TWO)
                    && !pos_row[0] && !pos_col[0];
`else
    assign win_ok = accept && (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (last_pix) begin
                row <= '0;
                col <= '0;
            end else if (pos_col == COL_LAST) begin
                row <= pos_row + 1'b1;
                col <= '0;
            end else begin
                row <= pos_row;
                col <= pos_col + 1'b1;
            end
        end else if (state == RUN) begin
            row <= '0;
            col <= '0;
        end
    end

    always_comb begin
        wshift = wreg;
        for (int r = 0; r < 3; r++) begin
            wshift[(r*3)*DATA_WIDTH +: DATA_WIDTH]   = wreg[(r*3+1)*DATA_WIDTH +: DATA_WIDTH];
            wshift[(r*3+1)*DATA_WIDTH +: DATA_WIDTH] = wreg[(r*3+2)*DATA_WIDTH +: DATA_WIDTH];
        end
        wshift[2*DATA_WIDTH +: DATA_WIDTH] = tap_r2;
        wshift[5*DATA_WIDTH +: DATA_WIDTH] = tap_r1;
        wshift[8*DATA_WIDTH +: DATA_WIDTH] = in_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wreg       <= '0;
            win        <= '0;
            win_valid  <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            win_valid  <= win_ok;
            frame_done <= last_pix;
            err        <= violation;
            if (accept) wreg <= wshift;
            if (win_ok) begin
                win     <= wshift;
                out_row <= pos_row - ROW_TWO;
                out_col <= pos_col - COL_TWO;
            end
        end
    end
endmodule

// File: tb/tb_conv_window_former.sv
// Directed bench for conv_window_former: scenario table plus reset sequence.
module tb_conv_window_former;
    localparam int DW = 16;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int WW = 9 * DW;
    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic in_valid = 1'b0;
    logic sof = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] tap_r1 = '0;
    logic [DW-1:0] tap_r2 = '0;
    logic win_valid, frame_done, err, busy;
    logic [WW-1:0] win;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    conv_window_former #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .sof(sof),
        .in_data(in_data), .tap_r1(tap_r1), .tap_r2(tap_r2),
        .win_valid(win_valid), .win(win), .out_row(out_row), .out_col(out_col),
        .frame_done(frame_done), .err(err), .busy(busy)
    );

    typedef struct {
        string name;
        int len;
        int sof_a;
        int sof_b;
        int drop;
        int wins;
        int dones;
        int errs;
        int first_k;
    } vec_t;

    // reference model state
    int hist[$];
    int fv[H][W];
    bit m_active;
    int m_nr, m_nc;
    logic e_valid, e_done, e_err, e_busy;
    logic [WW-1:0] e_win;
    logic [RW-1:0] e_row;
    logic [CW-1:0] e_col;
    int n_win, n_done, n_err, first_k;
    bit seen;
    logic [WW-1:0] first_win, last_win;

    function automatic vec_t mk(string n, int len, int sa, int sb, int dr,
                                int wn, int dn, int er, int fk);
        vec_t v;
        v.name = n; v.len = len; v.sof_a = sa; v.sof_b = sb; v.drop = dr;
        v.wins = wn; v.dones = dn; v.errs = er; v.first_k = fk;
        return v;
    endfunction

    function automatic logic [WW-1:0] ramp_win(int base);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*DW +: DW] = DW'(base + r*W + c);
        return w;
    endfunction

    task automatic chk(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("win_valid", WW'(win_valid), WW'(e_valid));
        chk("frame_done", WW'(frame_done), WW'(e_done));
        chk("err", WW'(err), WW'(e_err));
        chk("busy", WW'(busy), WW'(e_busy));
        chk("win", win, e_win);
        chk("out_row", WW'(out_row), WW'(e_row));
        chk("out_col", WW'(out_col), WW'(e_col));
    endtask

    task automatic model_reset();
        hist.delete();
        m_active = 0; m_nr = 0; m_nc = 0;
        e_valid = 0; e_done = 0; e_err = 0; e_busy = 0;
        e_win = '0; e_row = '0; e_col = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                fv[r][c] = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0; in_valid = 1'b0; sof = 1'b0; in_data = '0;
        tap_r1 = '0; tap_r2 = '0;
        model_reset();
        @(negedge clk);
        check_all();
        rstn = 1'b1;
        n_win = 0; n_done = 0; n_err = 0; first_k = -1; seen = 0;
    endtask

    task automatic step(input logic v, input logic s, input logic [DW-1:0] d, input int k);
        int pr, pc;
        bit acc, keep;
        @(negedge clk);
        in_valid = v; sof = s; in_data = d;
        tap_r1 = (hist.size() >= W)   ? DW'(hist[hist.size()-W])   : '0;
        tap_r2 = (hist.size() >= 2*W) ? DW'(hist[hist.size()-2*W]) : '0;
        if (v) hist.push_back(int'(d));
        acc = 0; pr = 0; pc = 0;
        e_err = 0; e_valid = 0; e_done = 0;
        if (v && s) begin
            e_err = m_active;
            acc = 1;
        end else if (v && m_active) begin
            acc = 1; pr = m_nr; pc = m_nc;
        end else if (!v && m_active) begin
            e_err = 1;
            m_active = 0;
        end
        if (acc) begin
            fv[pr][pc] = int'(d);
            m_active = 1;
            m_nc = (pc + 1) % W;
            m_nr = (pc == W-1) ? pr + 1 : pr;
            if (pr == H-1 && pc == W-1) begin
                e_done = 1; m_active = 0; m_nr = 0; m_nc = 0;
            end
            keep = 1;
`ifdef CONV_WINDOW_STRIDE2_EN
            keep = (pr % 2 == 0) && (pc % 2 == 0);
`endif
            if (pr >= 2 && pc >= 2 && keep) begin
                e_valid = 1;
                e_row = RW'(pr - 2);
                e_col = CW'(pc - 2);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e_win[(i*3+j)*DW +: DW] = DW'(fv[pr-2+i][pc-2+j]);
            end
        end
        e_busy = m_active;
        @(posedge clk);
        #1;
        check_all();
        if (win_valid) begin
            n_win++;
            last_win = win;
            if (!seen) begin first_win = win; seen = 1; end
            if (out_row == '0 && out_col == '0) first_k = k;
        end
        if (frame_done) n_done++;
        if (err) n_err++;
    endtask

    vec_t tbl[4];

    initial begin
`ifdef CONV_WINDOW_STRIDE2_EN
        tbl[0] = mk("ramp",  64, 0, -1, -1,  9, 1, 0, 18);
        tbl[1] = mk("b2b",  128, 0, 64, -1, 18, 2, 0, 82);
        tbl[2] = mk("drop",  40, 0, -1, 30,  3, 0, 1, 18);
        tbl[3] = mk("resof",104, 0, 40, -1, 15, 1, 1, 58);
`else
        tbl[0] = mk("ramp",  64, 0, -1, -1, 36, 1, 0, 18);
        tbl[1] = mk("b2b",  128, 0, 64, -1, 72, 2, 0, 82);
        tbl[2] = mk("drop",  40, 0, -1, 30, 10, 0, 1, 18);
        tbl[3] = mk("resof",104, 0, 40, -1, 54, 1, 1, 58);
`endif
        for (int i = 0; i < 4; i++) begin
            do_reset();
            for (int k = 0; k < tbl[i].len; k++)
                step(k != tbl[i].drop, (k == tbl[i].sof_a) || (k == tbl[i].sof_b),
                     DW'(k), k);
            step(1'b0, 1'b0, '0, -1);
            chk({tbl[i].name, "_wins"}, WW'(n_win), WW'(tbl[i].wins));
            chk({tbl[i].name, "_dones"}, WW'(n_done), WW'(tbl[i].dones));
            chk({tbl[i].name, "_errs"}, WW'(n_err), WW'(tbl[i].errs));
            chk({tbl[i].name, "_first_k"}, WW'(first_k), WW'(tbl[i].first_k));
            if (i == 0) begin
                chk("ramp_first_win", first_win, ramp_win(0));
`ifdef CONV_WINDOW_STRIDE2_EN
                chk("ramp_last_win", last_win, ramp_win(36));
`else
                chk("ramp_last_win", last_win, ramp_win(45));
`endif
            end
        end

        // asynchronous reset in the middle of a frame
        do_reset();
        for (int k = 0; k <= 25; k++)
            step(1'b1, k == 0, DW'(k), k);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rstn = 1'b1;
        n_win = 0; n_err = 0;
        for (int k = 0; k < 20; k++)
            step(1'b1, 1'b0, DW'(100 + k), k);
        chk("post_reset_wins", WW'(n_win), WW'(0));
        chk("post_reset_errs", WW'(n_err), WW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
